// File: rtl/prog_run_pkg.sv
// Shared types and defaults for the program run controller.
package prog_run_pkg;

    localparam int unsigned DefIw       = 9;
    localparam int unsigned DefPcw      = 10;
    localparam int unsigned DefNumProgs = 4;
    localparam int unsigned DefCcw      = 16;

    typedef enum logic [2:0] {
        StIdle,
        StArmed,
        StRun,
        StDone,
        StFault
    } run_state_t;

    // All-ones halt/NOP encoding for an instruction of width iw (iw <= 64).
    function automatic logic [63:0] nop_inst(input int unsigned iw);
        logic [63:0] v;
        v = '0;
        for (int unsigned i = 0; i < 64; i++) begin
            if (i < iw) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; clear has priority.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = '0;
        end else if (en_i && (q_q != '1)) begin
            q_d = q_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/prog_run_ctrl.sv
// Run controller: arms on Start, launches the selected program on Start's falling edge,
// squashes fetches outside RUN, counts RUN cycles and ends on halt decode or watchdog.
module prog_run_ctrl
    import prog_run_pkg::*;
#(
    parameter int unsigned IW        = DefIw,
    parameter int unsigned PCW       = DefPcw,
    parameter int unsigned NUM_PROGS = DefNumProgs,
    parameter int unsigned SELW      = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1,
    parameter int unsigned CCW       = DefCcw,
    parameter int unsigned TIMEOUT   = 0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [SELW-1:0]          prog_sel_i,
    input  logic [NUM_PROGS*PCW-1:0] prog_base_i,
    input  logic [IW-1:0]            inst_i,
    input  logic                     ctrl_ack_i,
    output logic [IW-1:0]            active_inst_o,
    output logic                     run_en_o,
    output logic                     pc_load_o,
    output logic [PCW-1:0]           pc_load_addr_o,
    output logic                     ack_o,
    output logic                     timeout_o,
    output logic [CCW-1:0]           cycle_count_o,
    output logic [CCW-1:0]           last_cycles_o
);

    localparam logic [IW-1:0] NopInst = IW'(nop_inst(IW));
    localparam int unsigned   WdLast  = TIMEOUT - 1;

    run_state_t     state_q, state_d;
    logic [CCW-1:0] last_q, last_d;
    logic [CCW-1:0] cnt;
    logic [CCW-1:0] cnt_inc_sat;
    logic           cnt_clr;
    logic           cnt_en;
    logic           wd_hit;
    logic [PCW-1:0] sel_base;

    // Out-of-range selects fall back to entry 0.
    always_comb begin
        sel_base = prog_base_i[0 +: PCW];
        for (int unsigned k = 0; k < NUM_PROGS; k++) begin
            if (32'(prog_sel_i) == k) begin
                sel_base = prog_base_i[k*PCW +: PCW];
            end
        end
    end

    assign cnt_inc_sat = (cnt == '1) ? cnt : cnt + CCW'(1);
    assign wd_hit      = (TIMEOUT != 0) && (32'(cnt) == WdLast);
    assign cnt_en      = (state_q == StRun);

    sat_counter #(
        .W(CCW)
    ) u_cycle_cnt (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .clr_i(cnt_clr),
        .en_i (cnt_en),
        .q_o  (cnt)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_clr = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) state_d = StArmed;
            end
            StArmed: begin
                if (!start_i) begin
                    state_d = StRun;
                    cnt_clr = 1'b1;
                end
            end
            StRun: begin
                // Abort beats halt, halt beats watchdog.
                if (start_i) begin
                    state_d = StArmed;
                end else if (ctrl_ack_i) begin
                    state_d = StDone;
                    last_d  = cnt_inc_sat;
                end else if (wd_hit) begin
                    state_d = StFault;
                    last_d  = CCW'(TIMEOUT);
                end
            end
            StDone, StFault: begin
                if (start_i) state_d = StArmed;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    assign run_en_o       = (state_q == StRun);
    assign active_inst_o  = run_en_o ? inst_i : NopInst;
    assign pc_load_o      = (state_q == StArmed);
    assign pc_load_addr_o = pc_load_o ? sel_base : prog_base_i[0 +: PCW];
    assign ack_o          = (state_q == StDone) || (state_q == StFault);
    assign timeout_o      = (state_q == StFault);
    assign cycle_count_o  = cnt;
    assign last_cycles_o  = last_q;

endmodule

// File: tb/tb_prog_run_ctrl.sv
// Bench for prog_run_ctrl: three configurations share stimulus and are checked against a
// run-level reference model every cycle, plus directed checks at the interesting points.
module tb_prog_run_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       ctrl_ack;
    logic [1:0] sel;
    logic [8:0] inst;
    logic [9:0] base [4];
    logic [39:0] base4;
    logic [29:0] base3;

    always #5 clk = ~clk;

    assign base4 = {base[3], base[2], base[1], base[0]};
    assign base3 = {base[2], base[1], base[0]};

    logic [8:0]  ai [3];
    logic        re [3];
    logic        pl [3];
    logic        ak [3];
    logic        to [3];
    logic [9:0]  pa [3];
    logic [15:0] cc0, lc0, cc1, lc1;
    logic [3:0]  cc2, lc2;

    prog_run_ctrl #(.IW(9), .PCW(10), .NUM_PROGS(4), .CCW(16), .TIMEOUT(0)) u0 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .prog_sel_i(sel), .prog_base_i(base4),
        .inst_i(inst), .ctrl_ack_i(ctrl_ack), .active_inst_o(ai[0]), .run_en_o(re[0]),
        .pc_load_o(pl[0]), .pc_load_addr_o(pa[0]), .ack_o(ak[0]), .timeout_o(to[0]),
        .cycle_count_o(cc0), .last_cycles_o(lc0)
    );

    prog_run_ctrl #(.IW(9), .PCW(10), .NUM_PROGS(3), .CCW(16), .TIMEOUT(8)) u1 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .prog_sel_i(sel), .prog_base_i(base3),
        .inst_i(inst), .ctrl_ack_i(ctrl_ack), .active_inst_o(ai[1]), .run_en_o(re[1]),
        .pc_load_o(pl[1]), .pc_load_addr_o(pa[1]), .ack_o(ak[1]), .timeout_o(to[1]),
        .cycle_count_o(cc1), .last_cycles_o(lc1)
    );

    prog_run_ctrl #(.IW(9), .PCW(10), .NUM_PROGS(4), .CCW(4), .TIMEOUT(0)) u2 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .prog_sel_i(sel), .prog_base_i(base4),
        .inst_i(inst), .ctrl_ack_i(ctrl_ack), .active_inst_o(ai[2]), .run_en_o(re[2]),
        .pc_load_o(pl[2]), .pc_load_addr_o(pa[2]), .ack_o(ak[2]), .timeout_o(to[2]),
        .cycle_count_o(cc2), .last_cycles_o(lc2)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: per configuration, which phase the run is in and how many RUN
    // cycles have elapsed as an unbounded integer; saturation applied on observation.
    int ccmax [3] = '{65535, 65535, 15};
    int tlim  [3] = '{0, 8, 0};
    int np    [3] = '{4, 3, 4};
    bit m_armed [3];
    bit m_run   [3];
    bit m_fin   [3];
    bit m_tmo   [3];
    int m_rc    [3];
    int m_last  [3];

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int obs_cc(input int d);
        case (d)
            0:       return int'(cc0);
            1:       return int'(cc1);
            default: return int'(cc2);
        endcase
    endfunction

    function automatic int obs_lc(input int d);
        case (d)
            0:       return int'(lc0);
            1:       return int'(lc1);
            default: return int'(lc2);
        endcase
    endfunction

    task automatic chk(input string tag, input int d, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[dut%0d]: observed=%0h expected=%0h", tag, d, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_armed[d] = 1'b0;
            m_run[d]   = 1'b0;
            m_fin[d]   = 1'b0;
            m_tmo[d]   = 1'b0;
            m_rc[d]    = 0;
            m_last[d]  = 0;
        end
    endtask

    task automatic model_step();
        for (int d = 0; d < 3; d++) begin
            if (m_run[d]) begin
                int n;
                n = m_rc[d] + 1;
                m_rc[d] = n;
                if (start) begin
                    m_run[d]   = 1'b0;
                    m_armed[d] = 1'b1;
                end else if (ctrl_ack) begin
                    m_run[d]  = 1'b0;
                    m_fin[d]  = 1'b1;
                    m_tmo[d]  = 1'b0;
                    m_last[d] = min_i(n, ccmax[d]);
                end else if (tlim[d] != 0 && n == tlim[d]) begin
                    m_run[d]  = 1'b0;
                    m_fin[d]  = 1'b1;
                    m_tmo[d]  = 1'b1;
                    m_last[d] = tlim[d];
                end
            end else if (m_armed[d]) begin
                if (!start) begin
                    m_armed[d] = 1'b0;
                    m_run[d]   = 1'b1;
                    m_rc[d]    = 0;
                end
            end else if (start) begin
                m_fin[d]   = 1'b0;
                m_tmo[d]   = 1'b0;
                m_armed[d] = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 3; d++) begin
            int esel;
            esel = (int'(sel) < np[d]) ? int'(sel) : 0;
            chk("run_en", d, re[d], m_run[d]);
            chk("active_inst", d, ai[d], m_run[d] ? inst : 9'h1FF);
            chk("pc_load", d, pl[d], m_armed[d]);
            if (m_armed[d]) chk("pc_load_addr", d, pa[d], base[esel]);
            chk("ack", d, ak[d], m_fin[d]);
            chk("timeout", d, to[d], m_fin[d] && m_tmo[d]);
            chk("cycle_count", d, obs_cc(d), min_i(m_rc[d], ccmax[d]));
            chk("last_cycles", d, obs_lc(d), m_last[d]);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        ctrl_ack = 1'b0;
        sel      = 2'd0;
        inst     = 9'h000;
        base[0]  = 10'h011;
        base[1]  = 10'h022;
        base[2]  = 10'h040;
        base[3]  = 10'h3A5;
        model_reset();
        #1;
        check_all();
        for (int d = 0; d < 3; d++) chk("reset_pc_addr", d, pa[d], 10'h011);
        cycle();
        cycle();
        rst = 1'b0;

        // Normal run from entry 2, halt in RUN cycle 5.
        sel   = 2'd2;
        start = 1'b1;
        repeat (3) cycle();
        chk("t1_pc_addr", 0, pa[0], 10'h040);
        chk("t1_pc_load", 1, pl[1], 1'b1);
        start = 1'b0;
        repeat (5) begin
            inst = 9'($urandom);
            cycle();
        end
        chk("t1_cycle4", 0, cc0, 16'd4);
        ctrl_ack = 1'b1;
        cycle();
        ctrl_ack = 1'b0;
        chk("t1_ack", 0, ak[0], 1'b1);
        chk("t1_last", 0, lc0, 16'd5);
        chk("t1_timeout", 0, to[0], 1'b0);
        chk("t1_last", 1, lc1, 16'd5);

        // Watchdog on the TIMEOUT=8 instance.
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (9) cycle();
        chk("t2_ack", 1, ak[1], 1'b1);
        chk("t2_timeout", 1, to[1], 1'b1);
        chk("t2_last", 1, lc1, 16'd8);
        chk("t2_still_run", 0, re[0], 1'b1);
        start = 1'b1;
        cycle();
        chk("t2_ack_clr", 1, ak[1], 1'b0);
        chk("t2_tmo_clr", 1, to[1], 1'b0);

        // Abort by Start in RUN cycle 3.
        start = 1'b0;
        repeat (3) cycle();
        start = 1'b1;
        cycle();
        chk("t3_ack", 0, ak[0], 1'b0);
        chk("t3_last", 0, lc0, 16'd5);
        chk("t3_nop", 0, ai[0], 9'h1FF);
        chk("t3_last", 1, lc1, 16'd8);

        // Saturation on the CCW=4 instance.
        start = 1'b0;
        repeat (20) cycle();
        chk("t4_sat", 2, cc2, 4'd15);
        ctrl_ack = 1'b1;
        cycle();
        ctrl_ack = 1'b0;
        chk("t4_last", 2, lc2, 4'd15);
        chk("t4_last", 0, lc0, 16'd20);

        // Out-of-range select, and halt colliding with the watchdog cycle.
        sel   = 2'd3;
        start = 1'b1;
        cycle();
        chk("t5_sel_fallback", 1, pa[1], 10'h011);
        chk("t5_sel3", 0, pa[0], 10'h3A5);
        start = 1'b0;
        repeat (8) cycle();
        ctrl_ack = 1'b1;
        cycle();
        ctrl_ack = 1'b0;
        chk("t5_ack", 1, ak[1], 1'b1);
        chk("t5_timeout", 1, to[1], 1'b0);
        chk("t5_last", 1, lc1, 16'd8);

        // Asynchronous reset between edges in the middle of a run.
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (4) cycle();
        #2 rst = 1'b1;
        #1;
        model_reset();
        for (int d = 0; d < 3; d++) begin
            chk("t6_run_en", d, re[d], 1'b0);
            chk("t6_nop", d, ai[d], 9'h1FF);
            chk("t6_ack", d, ak[d], 1'b0);
            chk("t6_count", d, obs_cc(d), 0);
            chk("t6_last", d, obs_lc(d), 0);
            chk("t6_pc_addr", d, pa[d], base[0]);
        end
        cycle();
        rst = 1'b0;

        // Random traffic.
        repeat (400) begin
            if ($urandom_range(0, 9) == 0) start = ~start;
            ctrl_ack = ($urandom_range(0, 11) == 0);
            sel      = 2'($urandom);
            inst     = 9'($urandom);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
